cla_sum_pipe: RTL and testbench

//  Carry look-ahead consumer stage. Sits directly downstream of the per-bit propagate/generate generator.

---
 rtl/cla_sum_pipe.sv | 187 ++++++++++++++++++
 tb/tb_cla_sum_pipe.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_sum_pipe.sv
// cla_sum_pipe: two-stage elastic carry look-ahead sum stage.
//   Stage 1 registers the per-bit propagate/generate vectors and carry-in,
//   together with the per-group block propagate/generate terms.
//   Stage 2 resolves the group carries, ripples the carries inside each group,
//   and registers sum, carry-out and signed overflow.
// Vector ports use ascending ranges [0:WIDTH-1] with index 0 = LSB, which is
// the bit order the upstream P/G generator uses.
// Optional feature macro: CLA_FLAGS_EN adds registered zero/neg result flags.
module cla_sum_pipe #(
  parameter int WIDTH = 8,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:WIDTH-1] p_in,
  input  logic [0:WIDTH-1] g_in,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:WIDTH-1] sum,
  output logic             cout,
  output logic             ovf
`ifdef CLA_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg
`endif
);

  localparam int NGRP = WIDTH / GROUP;

  // Handshake state
  logic rdy_q;
  logic s1_valid_q, s1_valid_d;
  logic out_valid_q, out_valid_d;
  logic adv1, adv2;

  // Stage 1 state
  logic [0:WIDTH-1] p_q, g_q;
  logic             cin_q;
  logic [NGRP-1:0]  gp_q, gp_d;
  logic [NGRP-1:0]  gg_q, gg_d;

  // Stage 2 state
  logic [0:WIDTH-1] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [NGRP:0]    c_grp;
  logic             c_run;
  logic             c_msb;
`ifdef CLA_FLAGS_EN
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
`endif

  // Stage 2 can take a new entry when it is empty or its entry leaves this
  // cycle. in_ready follows out_ready combinationally so a full pipe keeps
  // streaming without a bubble. rdy_q holds in_ready low through reset and
  // for the first edge after release.
  assign adv2     = s1_valid_q & (~out_valid_q | out_ready);
  assign in_ready = rdy_q & (~s1_valid_q | adv2);
  assign adv1     = in_valid & in_ready;

  // Handshake next-state for both stage valid flags
  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    if (adv1) begin
      s1_valid_d = 1'b1;
    end else if (adv2) begin
      s1_valid_d = 1'b0;
    end
    if (adv2) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Block propagate/generate per group, walking each group from its LSB up
  always_comb begin
    gp_d = '1;
    gg_d = '0;
    for (int k = 0; k < NGRP; k++) begin
      for (int j = 0; j < GROUP; j++) begin
        gg_d[k] = g_in[k*GROUP + j] | (p_in[k*GROUP + j] & gg_d[k]);
        gp_d[k] = gp_d[k] & p_in[k*GROUP + j];
      end
    end
  end

  // Group carries from block terms, then intra-group ripple seeded by them.
  // P and G are used verbatim; P&G both set at a bit is legal input.
  always_comb begin
    c_grp    = '0;
    c_grp[0] = cin_q;
    for (int k = 0; k < NGRP; k++) begin
      c_grp[k+1] = gg_q[k] | (gp_q[k] & c_grp[k]);
    end
    sum_d = '0;
    c_msb = 1'b0;
    c_run = 1'b0;
    for (int k = 0; k < NGRP; k++) begin
      c_run = c_grp[k];
      for (int j = 0; j < GROUP; j++) begin
        if (k*GROUP + j == WIDTH-1) begin
          c_msb = c_run;
        end
        sum_d[k*GROUP + j] = p_q[k*GROUP + j] ^ c_run;
        c_run = g_q[k*GROUP + j] | (p_q[k*GROUP + j] & c_run);
      end
    end
    cout_d = c_grp[NGRP];
    ovf_d  = c_grp[NGRP] ^ c_msb;
  end

`ifdef CLA_FLAGS_EN
  // Result flags derived from the same next-sum so they align with sum
  always_comb begin
    zero_d = ~|sum_d;
    neg_d  = sum_d[WIDTH-1];
  end
`endif

  // Handshake registers; reset empties both stages immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      rdy_q       <= 1'b1;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Stage 1 capture on input transfer; holds while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= '0;
      g_q   <= '0;
      cin_q <= 1'b0;
      gp_q  <= '0;
      gg_q  <= '0;
    end else if (adv1) begin
      p_q   <= p_in;
      g_q   <= g_in;
      cin_q <= cin;
      gp_q  <= gp_d;
      gg_q  <= gg_d;
    end
  end

  // Stage 2 capture on advance; result stays stable while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
`ifdef CLA_FLAGS_EN
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
`endif
    end else if (adv2) begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
`ifdef CLA_FLAGS_EN
      zero_q <= zero_d;
      neg_q  <= neg_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
`ifdef CLA_FLAGS_EN
  assign zero      = zero_q;
  assign neg       = neg_q;
`endif

endmodule

// File: tb/tb_cla_sum_pipe.sv
// Self-checking bench for cla_sum_pipe (WIDTH=8, GROUP=4).
module tb_cla_sum_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [0:7] p_in;
  logic [0:7] g_in;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [0:7] sum;
  logic       cout;
  logic       ovf;
`ifdef CLA_FLAGS_EN
  logic       zero;
  logic       neg;
`endif

  cla_sum_pipe #(.WIDTH(8), .GROUP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p_in      (p_in),
    .g_in      (g_in),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
`ifdef CLA_FLAGS_EN
    ,
    .zero      (zero),
    .neg       (neg)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] s;
    logic       co;
    logic       ov;
  } exp_t;

  typedef struct {
    logic [7:0] p;
    logic [7:0] g;
    logic       c;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   popped = 0;
  bit   mon_en = 0;
  exp_t cur_exp;
  exp_t sb_q[$];
  bit   prev_stall = 0;
  logic [7:0] prev_sum;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [0:7] asc(input logic [7:0] v);
    logic [0:7] r;
    for (int i = 0; i < 8; i++) r[i] = v[i];
    return r;
  endfunction

  function automatic logic [7:0] dsc(input logic [0:7] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[i];
    return r;
  endfunction

  function automatic exp_t model_add(input logic [7:0] a, input logic [7:0] b, input logic c);
    exp_t e;
    logic [8:0] t;
    t    = {1'b0, a} + {1'b0, b} + {8'd0, c};
    e.s  = t[7:0];
    e.co = t[8];
    e.ov = (a[7] == b[7]) && (t[7] != a[7]);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard: push on input transfer, pop/compare on output transfer,
  // and require a stalled output to stay valid and unchanged.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (prev_stall) begin
        chk("stall_valid_held", {31'd0, out_valid}, 32'd1);
        chk("stall_sum_held", {24'd0, dsc(sum)}, {24'd0, prev_sum});
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          popped++;
          chk("sum", {24'd0, dsc(sum)}, {24'd0, e.s});
          chk("cout", {31'd0, cout}, {31'd0, e.co});
          chk("ovf", {31'd0, ovf}, {31'd0, e.ov});
`ifdef CLA_FLAGS_EN
          chk("zero", {31'd0, zero}, {31'd0, (e.s == 8'd0)});
          chk("neg", {31'd0, neg}, {31'd0, e.s[7]});
`endif
        end
      end
      if (in_valid && in_ready) sb_q.push_back(cur_exp);
      prev_stall = out_valid && !out_ready;
      prev_sum   = dsc(sum);
    end else begin
      prev_stall = 0;
    end
  end

  task automatic send(input logic [7:0] p, input logic [7:0] g, input logic c, input exp_t e);
    bit ok;
    in_valid = 1'b1;
    p_in     = asc(p);
    g_in     = asc(g);
    cin      = c;
    cur_exp  = e;
    ok       = 0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 30 && (sb_q.size() != 0 || out_valid); n++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", sb_q.size(), 32'd0);
  endtask

  function automatic exp_t mk(input logic [7:0] s, input logic co, input logic ov);
    exp_t e;
    e.s  = s;
    e.co = co;
    e.ov = ov;
    return e;
  endfunction

  vec_t tbl[11];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   t0;
    int   p0;
    logic [7:0] a, b;
    logic       c;

    tbl[0]  = '{p:8'h7E, g:8'h01, c:1'b0, s:8'h80, co:1'b0, ov:1'b1};
    tbl[1]  = '{p:8'hFE, g:8'h01, c:1'b0, s:8'h00, co:1'b1, ov:1'b0};
    tbl[2]  = '{p:8'hFF, g:8'h00, c:1'b1, s:8'h00, co:1'b1, ov:1'b0};
    tbl[3]  = '{p:8'h00, g:8'h00, c:1'b0, s:8'h00, co:1'b0, ov:1'b0};
    tbl[4]  = '{p:8'h00, g:8'h80, c:1'b0, s:8'h00, co:1'b1, ov:1'b1};
    tbl[5]  = '{p:8'h26, g:8'h10, c:1'b1, s:8'h47, co:1'b0, ov:1'b0};
    tbl[6]  = '{p:8'h0E, g:8'h01, c:1'b0, s:8'h10, co:1'b0, ov:1'b0};
    tbl[7]  = '{p:8'h7F, g:8'h00, c:1'b1, s:8'h80, co:1'b0, ov:1'b1};
    tbl[8]  = '{p:8'h01, g:8'h01, c:1'b0, s:8'h03, co:1'b0, ov:1'b0};
    tbl[9]  = '{p:8'hFF, g:8'hFF, c:1'b1, s:8'h00, co:1'b1, ov:1'b0};
    tbl[10] = '{p:8'h55, g:8'hAA, c:1'b0, s:8'hA9, co:1'b1, ov:1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    p_in      = '0;
    g_in      = '0;
    cin       = 1'b0;
    cur_exp   = mk(8'h00, 1'b0, 1'b0);

    // Reset state
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {24'd0, dsc(sum)}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_release", {31'd0, in_ready}, 32'd1);
    mon_en = 1;

    // Latency: accepted on edge N, result visible after edge N+1
    send(tbl[0].p, tbl[0].g, tbl[0].c, mk(tbl[0].s, tbl[0].co, tbl[0].ov));
    chk("lat_not_yet_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_sum", {24'd0, dsc(sum)}, 32'h80);
    drain();

    // Table vectors, back to back
    for (int i = 0; i < 11; i++) begin
      send(tbl[i].p, tbl[i].g, tbl[i].c, mk(tbl[i].s, tbl[i].co, tbl[i].ov));
    end
    drain();

    // 16 random vectors, one per cycle, against an A+B+cin model
    t0 = cyc;
    p0 = popped;
    for (int i = 0; i < 16; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      c = 1'($urandom);
      send(a ^ b, a & b, c, model_add(a, b, c));
    end
    chk("throughput_cycles", cyc - t0, 32'd16);
    drain();
    chk("random_delivered", popped - p0, 32'd16);

    // Stall: out_ready low, three vectors offered, two accepted
    out_ready = 1'b0;
    send(8'h7E, 8'h01, 1'b0, model_add(8'h7F, 8'h01, 1'b0));
    send(8'hFE, 8'h01, 1'b0, model_add(8'hFF, 8'h01, 1'b0));
    e        = model_add(8'h10, 8'h22, 1'b1);
    in_valid = 1'b1;
    p_in     = asc(8'h10 ^ 8'h22);
    g_in     = asc(8'h10 & 8'h22);
    cin      = 1'b1;
    cur_exp  = e;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      chk("stall_in_ready_low", {31'd0, in_ready}, 32'd0);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_sum_first", {24'd0, dsc(sum)}, 32'h80);
    end
    p0 = popped;
    out_ready = 1'b1;
    send(8'h10 ^ 8'h22, 8'h10 & 8'h22, 1'b1, e);
    drain();
    chk("stall_delivered", popped - p0, 32'd3);

    // Reset while both stages hold data
    out_ready = 1'b0;
    send(8'h0E, 8'h01, 1'b0, model_add(8'h0F, 8'h01, 1'b0));
    send(8'h26, 8'h10, 1'b1, model_add(8'h12, 8'h34, 1'b1));
    #3;
    rst_n  = 1'b0;
    mon_en = 0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_sum", {24'd0, dsc(sum)}, 32'd0);
    sb_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out_still_empty", {31'd0, out_valid}, 32'd0);
    mon_en = 1;
    p0 = popped;
    send(8'hFE, 8'h01, 1'b0, model_add(8'hFF, 8'h01, 1'b0));
    drain();
    chk("midrst_next_delivered", popped - p0, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
